// File: rtl/connect6_board_engine.sv
// Connect6 board engine: holds occupancy and saturating weights per cell, accepts
// opponent stones over valid/ready, and picks our stones with a one-cell-per-cycle raster scan.
module connect6_board_engine #(
    parameter int BOARD_N        = 19,
    parameter int COORD_W        = 5,
    parameter int WEIGHT_W       = 4,
    parameter int DEFAULT_WEIGHT = 6,
    parameter int DEF_THRESH     = 10,
    parameter int OFF_THRESH     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               opp_valid,
    output logic               opp_ready,
    input  logic               opp_two,
    input  logic [COORD_W-1:0] opp_x1,
    input  logic [COORD_W-1:0] opp_y1,
    input  logic [COORD_W-1:0] opp_x2,
    input  logic [COORD_W-1:0] opp_y2,
    input  logic               start,
    input  logic               n_stones,
    output logic               busy,
    output logic               mv_valid,
    output logic [COORD_W-1:0] mv_x,
    output logic [COORD_W-1:0] mv_y,
    output logic [1:0]         mv_class,
    output logic               done,
    output logic               err_illegal,
    output logic               board_full
);
    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IDX_W = $clog2(CELLS);
    localparam logic [COORD_W-1:0]  LAST   = COORD_W'(BOARD_N - 1);
    localparam logic [WEIGHT_W-1:0] W_MAX  = '1;
    localparam logic [WEIGHT_W-1:0] W_INIT = WEIGHT_W'(DEFAULT_WEIGHT);

    typedef enum logic [2:0] {IDLE, OPP1, OPP2, SCAN, COMMIT, DONE} state_t;
    typedef enum logic [1:0] {C_EMPTY, C_OPP, C_OURS} cell_t;

    function automatic logic coord_ok(input logic [COORD_W-1:0] c);
        return int'(c) < BOARD_N;
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return IDX_W'(int'(x) * BOARD_N + int'(y));
    endfunction

    function automatic logic [1:0] classify(input logic [WEIGHT_W-1:0] w);
        if (int'(w) >= DEF_THRESH)      return 2'd2;
        else if (int'(w) <= OFF_THRESH) return 2'd1;
        else                            return 2'd0;
    endfunction

    function automatic logic [WEIGHT_W-1:0] sat_inc(input logic [WEIGHT_W-1:0] w);
        return (w == W_MAX) ? w : w + 1'b1;
    endfunction

    function automatic logic [WEIGHT_W-1:0] sat_dec(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? w : w - 1'b1;
    endfunction

    state_t               state_q, state_d;
    cell_t                cell_q [CELLS];
    cell_t                cell_d [CELLS];
    logic [WEIGHT_W-1:0]  wt_q [CELLS];
    logic [WEIGHT_W-1:0]  wt_d [CELLS];
    logic [COORD_W-1:0]   ox1_q, oy1_q, ox2_q, oy2_q, ox1_d, oy1_d, ox2_d, oy2_d;
    logic                 otwo_q, otwo_d, nst_q, nst_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [COORD_W-1:0]   sx_q, sy_q, sx_d, sy_d;
    logic                 best_vld_q, best_vld_d;
    logic [COORD_W-1:0]   best_x_q, best_y_q, best_x_d, best_y_d;
    logic [1:0]           best_cls_q, best_cls_d;
    logic                 mv_valid_q, mv_valid_d, done_q, done_d, err_q, err_d;
    logic                 full_q, full_d, busy_q, busy_d, ready_q, ready_d;
    logic [COORD_W-1:0]   mv_x_q, mv_y_q, mv_x_d, mv_y_d;
    logic [1:0]           mv_class_q, mv_class_d;

    logic                 place_en, place_ours;
    logic [COORD_W-1:0]   place_x, place_y;
    logic                 in1_bad, s1_bad, s2_bad;
    logic [IDX_W-1:0]     scan_idx;
    logic [1:0]           scan_cls;

    assign scan_idx = cell_idx(sx_q, sy_q);
    assign scan_cls = classify(wt_q[scan_idx]);

    // Legality lookups: out-of-range coordinates never touch the cell array.
    always_comb begin
        in1_bad = 1'b1;
        s1_bad  = 1'b1;
        s2_bad  = 1'b1;
        if (coord_ok(opp_x1) && coord_ok(opp_y1)) in1_bad = (cell_q[cell_idx(opp_x1, opp_y1)] != C_EMPTY);
        if (coord_ok(ox1_q) && coord_ok(oy1_q))   s1_bad  = (cell_q[cell_idx(ox1_q, oy1_q)] != C_EMPTY);
        if (coord_ok(ox2_q) && coord_ok(oy2_q))   s2_bad  = (cell_q[cell_idx(ox2_q, oy2_q)] != C_EMPTY);
    end

    always_comb begin
        state_d    = state_q;
        cell_d     = cell_q;
        wt_d       = wt_q;
        ox1_d      = ox1_q;
        oy1_d      = oy1_q;
        ox2_d      = ox2_q;
        oy2_d      = oy2_q;
        otwo_d     = otwo_q;
        nst_d      = nst_q;
        cnt_d      = cnt_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        best_vld_d = best_vld_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        best_cls_d = best_cls_q;
        mv_valid_d = 1'b0;
        mv_x_d     = mv_x_q;
        mv_y_d     = mv_y_q;
        mv_class_d = mv_class_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        full_d     = full_q;
        place_en   = 1'b0;
        place_ours = 1'b0;
        place_x    = '0;
        place_y    = '0;

        case (state_q)
            IDLE: begin
                if (opp_valid) begin
                    ox1_d   = opp_x1;
                    oy1_d   = opp_y1;
                    ox2_d   = opp_x2;
                    oy2_d   = opp_y2;
                    otwo_d  = opp_two;
                    // err is registered, so judge stone 1 now to have it visible during OPP1
                    err_d   = in1_bad;
                    state_d = OPP1;
                end else if (start) begin
                    nst_d      = n_stones;
                    cnt_d      = 2'd0;
                    sx_d       = '0;
                    sy_d       = '0;
                    best_vld_d = 1'b0;
                    state_d    = SCAN;
                end
            end
            OPP1: begin
                if (!s1_bad) begin
                    place_en = 1'b1;
                    place_x  = ox1_q;
                    place_y  = oy1_q;
                end
                if (otwo_q) begin
                    // stone 2 also collides with stone 1 if stone 1 is being placed on the same cell
                    err_d   = s2_bad || (!s1_bad && ox1_q == ox2_q && oy1_q == oy2_q);
                    state_d = OPP2;
                end else begin
                    state_d = IDLE;
                end
            end
            OPP2: begin
                if (!s2_bad) begin
                    place_en = 1'b1;
                    place_x  = ox2_q;
                    place_y  = oy2_q;
                end
                state_d = IDLE;
            end
            SCAN: begin
                if (cell_q[scan_idx] == C_EMPTY && (!best_vld_q || scan_cls > best_cls_q)) begin
                    best_vld_d = 1'b1;
                    best_x_d   = sx_q;
                    best_y_d   = sy_q;
                    best_cls_d = scan_cls;
                end
                if (sy_q == LAST) begin
                    sy_d = '0;
                    if (sx_q == LAST) state_d = COMMIT;
                    else              sx_d = sx_q + 1'b1;
                end else begin
                    sy_d = sy_q + 1'b1;
                end
            end
            COMMIT: begin
                if (best_vld_q) begin
                    place_en   = 1'b1;
                    place_ours = 1'b1;
                    place_x    = best_x_q;
                    place_y    = best_y_q;
                    mv_valid_d = 1'b1;
                    mv_x_d     = best_x_q;
                    mv_y_d     = best_y_q;
                    mv_class_d = best_cls_q;
                    cnt_d      = cnt_q + 2'd1;
                    if (nst_q && cnt_q == 2'd0) begin
                        sx_d       = '0;
                        sy_d       = '0;
                        best_vld_d = 1'b0;
                        state_d    = SCAN;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    full_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (place_en) begin
            cell_d[cell_idx(place_x, place_y)] = place_ours ? C_OURS : C_OPP;
            for (int dx = -1; dx <= 1; dx++) begin
                for (int dy = -1; dy <= 1; dy++) begin
                    if ((dx != 0 || dy != 0) &&
                        int'(place_x) + dx >= 0 && int'(place_x) + dx < BOARD_N &&
                        int'(place_y) + dy >= 0 && int'(place_y) + dy < BOARD_N) begin
                        wt_d[IDX_W'((int'(place_x) + dx) * BOARD_N + int'(place_y) + dy)] =
                            place_ours ? sat_dec(wt_q[IDX_W'((int'(place_x) + dx) * BOARD_N + int'(place_y) + dy)])
                                       : sat_inc(wt_q[IDX_W'((int'(place_x) + dx) * BOARD_N + int'(place_y) + dy)]);
                    end
                end
            end
        end

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cell_q     <= '{default: C_EMPTY};
            wt_q       <= '{default: W_INIT};
            otwo_q     <= 1'b0;
            nst_q      <= 1'b0;
            cnt_q      <= 2'd0;
            sx_q       <= '0;
            sy_q       <= '0;
            best_vld_q <= 1'b0;
            best_cls_q <= 2'd0;
            mv_valid_q <= 1'b0;
            mv_x_q     <= '0;
            mv_y_q     <= '0;
            mv_class_q <= 2'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cell_q     <= cell_d;
            wt_q       <= wt_d;
            otwo_q     <= otwo_d;
            nst_q      <= nst_d;
            cnt_q      <= cnt_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            best_vld_q <= best_vld_d;
            best_cls_q <= best_cls_d;
            mv_valid_q <= mv_valid_d;
            mv_x_q     <= mv_x_d;
            mv_y_q     <= mv_y_d;
            mv_class_q <= mv_class_d;
            done_q     <= done_d;
            err_q      <= err_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    // Coordinate holding registers are only read when qualified by state.
    always_ff @(posedge clk) begin
        ox1_q    <= ox1_d;
        oy1_q    <= oy1_d;
        ox2_q    <= ox2_d;
        oy2_q    <= oy2_d;
        best_x_q <= best_x_d;
        best_y_q <= best_y_d;
    end

    assign opp_ready   = ready_q;
    assign busy        = busy_q;
    assign mv_valid    = mv_valid_q;
    assign mv_x        = mv_x_q;
    assign mv_y        = mv_y_q;
    assign mv_class    = mv_class_q;
    assign done        = done_q;
    assign err_illegal = err_q;
    assign board_full  = full_q;
endmodule

// File: tb/tb_connect6_board_engine.sv
// Directed bench for connect6_board_engine: a 19x19 instance for move selection and
// handshake rules, and a 3x3 instance for weight saturation and the full-board path.
module tb_connect6_board_engine;
    logic       clk;
    logic       rst, opp_valid, opp_two, start, n_stones;
    logic [4:0] opp_x1, opp_y1, opp_x2, opp_y2;
    logic       opp_ready, busy, mv_valid, done, err_illegal, board_full;
    logic [4:0] mv_x, mv_y;
    logic [1:0] mv_class;

    logic       rst3, opp_valid3, opp_two3, start3, n_stones3;
    logic [1:0] opp_x13, opp_y13, opp_x23, opp_y23;
    logic       opp_ready3, busy3, mv_valid3, done3, err_illegal3, board_full3;
    logic [1:0] mv_x3, mv_y3;
    logic [1:0] mv_class3;

    int         n_checks = 0;
    int         n_fail = 0;
    int         mv_n, done_k;
    int         mv_k [4];
    logic [4:0] mv_xs [4];
    logic [4:0] mv_ys [4];
    logic [1:0] mv_cs [4];
    logic       e1, e2;

    connect6_board_engine dut (
        .clk(clk), .rst(rst), .opp_valid(opp_valid), .opp_ready(opp_ready), .opp_two(opp_two),
        .opp_x1(opp_x1), .opp_y1(opp_y1), .opp_x2(opp_x2), .opp_y2(opp_y2),
        .start(start), .n_stones(n_stones), .busy(busy), .mv_valid(mv_valid),
        .mv_x(mv_x), .mv_y(mv_y), .mv_class(mv_class), .done(done),
        .err_illegal(err_illegal), .board_full(board_full)
    );

    connect6_board_engine #(
        .BOARD_N(3), .COORD_W(2), .WEIGHT_W(4), .DEFAULT_WEIGHT(1), .DEF_THRESH(10), .OFF_THRESH(0)
    ) dut3 (
        .clk(clk), .rst(rst3), .opp_valid(opp_valid3), .opp_ready(opp_ready3), .opp_two(opp_two3),
        .opp_x1(opp_x13), .opp_y1(opp_y13), .opp_x2(opp_x23), .opp_y2(opp_y23),
        .start(start3), .n_stones(n_stones3), .busy(busy3), .mv_valid(mv_valid3),
        .mv_x(mv_x3), .mv_y(mv_y3), .mv_class(mv_class3), .done(done3),
        .err_illegal(err_illegal3), .board_full(board_full3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_big();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic reset_small();
        @(negedge clk); rst3 = 1'b1;
        @(posedge clk); @(negedge clk); rst3 = 1'b0;
    endtask

    task automatic send_opp(input logic [4:0] x1, input logic [4:0] y1,
                            input logic [4:0] x2, input logic [4:0] y2, input logic two);
        e1 = 1'b0; e2 = 1'b0;
        @(negedge clk);
        opp_valid = 1'b1; opp_x1 = x1; opp_y1 = y1; opp_x2 = x2; opp_y2 = y2; opp_two = two;
        @(posedge clk); @(negedge clk);
        opp_valid = 1'b0;
        e1 = err_illegal;
        @(posedge clk); @(negedge clk);
        if (two) begin
            e2 = err_illegal;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic send_opp3(input logic [1:0] x1, input logic [1:0] y1,
                             input logic [1:0] x2, input logic [1:0] y2, input logic two);
        e1 = 1'b0; e2 = 1'b0;
        @(negedge clk);
        opp_valid3 = 1'b1; opp_x13 = x1; opp_y13 = y1; opp_x23 = x2; opp_y23 = y2; opp_two3 = two;
        @(posedge clk); @(negedge clk);
        opp_valid3 = 1'b0;
        e1 = err_illegal3;
        @(posedge clk); @(negedge clk);
        if (two) begin
            e2 = err_illegal3;
            @(posedge clk); @(negedge clk);
        end
    endtask

    // k counts active edges after the edge that accepted start
    task automatic run_move(input logic ns);
        mv_n = 0; done_k = -1;
        @(negedge clk); start = 1'b1; n_stones = ns;
        @(posedge clk); @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk); @(negedge clk);
            if (mv_valid && mv_n < 4) begin
                mv_k[mv_n] = k; mv_xs[mv_n] = mv_x; mv_ys[mv_n] = mv_y; mv_cs[mv_n] = mv_class;
                mv_n++;
            end
            if (done) begin done_k = k; break; end
        end
    endtask

    task automatic run_move3(input logic ns);
        mv_n = 0; done_k = -1;
        @(negedge clk); start3 = 1'b1; n_stones3 = ns;
        @(posedge clk); @(negedge clk); start3 = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); @(negedge clk);
            if (mv_valid3 && mv_n < 4) begin
                mv_k[mv_n] = k; mv_xs[mv_n] = {3'b0, mv_x3}; mv_ys[mv_n] = {3'b0, mv_y3};
                mv_cs[mv_n] = mv_class3;
                mv_n++;
            end
            if (done3) begin done_k = k; break; end
        end
    endtask

    task automatic test_reset();
        reset_big();
        n_checks++; if (opp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_opp_ready got %b exp 1", opp_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if ({mv_valid, done, err_illegal, board_full} !== 4'b0) begin n_fail++;
            $display("FAIL reset_pulses got %b exp 0000", {mv_valid, done, err_illegal, board_full}); end
        n_checks++; if ({mv_x, mv_y, mv_class} !== 12'd0) begin n_fail++;
            $display("FAIL reset_mv_fields got %h exp 000", {mv_x, mv_y, mv_class}); end
    endtask

    task automatic test_single_move();
        run_move(1'b0);
        n_checks++; if (mv_n !== 1) begin n_fail++; $display("FAIL single_count got %0d exp 1", mv_n); end
        n_checks++; if (mv_k[0] !== 362) begin n_fail++; $display("FAIL single_latency got %0d exp 362", mv_k[0]); end
        n_checks++; if ({mv_xs[0], mv_ys[0], mv_cs[0]} !== {5'd0, 5'd0, 2'd0}) begin n_fail++;
            $display("FAIL single_move got (%0d,%0d) c%0d exp (0,0) c0", mv_xs[0], mv_ys[0], mv_cs[0]); end
        n_checks++; if (done_k !== 363) begin n_fail++; $display("FAIL single_done got %0d exp 363", done_k); end
    endtask

    task automatic test_back_to_back();
        reset_big();
        run_move(1'b1);
        n_checks++; if (mv_n !== 2) begin n_fail++; $display("FAIL b2b_count1 got %0d exp 2", mv_n); end
        n_checks++; if ({mv_xs[0], mv_ys[0], mv_xs[1], mv_ys[1]} !== {5'd0, 5'd0, 5'd0, 5'd1}) begin n_fail++;
            $display("FAIL b2b_moves1 got (%0d,%0d)(%0d,%0d) exp (0,0)(0,1)", mv_xs[0], mv_ys[0], mv_xs[1], mv_ys[1]); end
        n_checks++; if (mv_k[1] !== 724 || done_k !== 725) begin n_fail++;
            $display("FAIL b2b_timing got mv2=%0d done=%0d exp 724/725", mv_k[1], done_k); end
        run_move(1'b1);
        n_checks++; if (mv_n !== 2) begin n_fail++; $display("FAIL b2b_count2 got %0d exp 2", mv_n); end
        n_checks++; if ({mv_xs[0], mv_ys[0], mv_cs[0]} !== {5'd0, 5'd2, 2'd0}) begin n_fail++;
            $display("FAIL b2b_move3 got (%0d,%0d) c%0d exp (0,2) c0", mv_xs[0], mv_ys[0], mv_cs[0]); end
        n_checks++; if ({mv_xs[1], mv_ys[1], mv_cs[1]} !== {5'd1, 5'd1, 2'd1}) begin n_fail++;
            $display("FAIL b2b_move4 got (%0d,%0d) c%0d exp (1,1) c1", mv_xs[1], mv_ys[1], mv_cs[1]); end
    endtask

    task automatic test_defensive();
        reset_big();
        send_opp(5'd8, 5'd8, 5'd8, 5'd10, 1'b1);
        n_checks++; if ({e1, e2} !== 2'b00) begin n_fail++; $display("FAIL def_err_a got %b exp 00", {e1, e2}); end
        send_opp(5'd10, 5'd8, 5'd10, 5'd10, 1'b1);
        n_checks++; if ({e1, e2} !== 2'b00) begin n_fail++; $display("FAIL def_err_b got %b exp 00", {e1, e2}); end
        n_checks++; if (opp_ready !== 1'b1) begin n_fail++; $display("FAIL def_ready got %b exp 1", opp_ready); end
        run_move(1'b0);
        n_checks++; if (mv_n !== 1 || {mv_xs[0], mv_ys[0], mv_cs[0]} !== {5'd9, 5'd9, 2'd2}) begin n_fail++;
            $display("FAIL def_move got n=%0d (%0d,%0d) c%0d exp n=1 (9,9) c2", mv_n, mv_xs[0], mv_ys[0], mv_cs[0]); end
    endtask

    task automatic test_illegal();
        reset_big();
        send_opp(5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        n_checks++; if ({e1, e2} !== 2'b01) begin n_fail++; $display("FAIL ill_dup got %b exp 01", {e1, e2}); end
        send_opp(5'd19, 5'd3, 5'd0, 5'd0, 1'b0);
        n_checks++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL ill_range got %b exp 1", e1); end
        send_opp(5'd25, 5'd0, 5'd5, 5'd5, 1'b1);
        n_checks++; if ({e1, e2} !== 2'b10) begin n_fail++; $display("FAIL ill_second_kept got %b exp 10", {e1, e2}); end
        send_opp(5'd5, 5'd5, 5'd0, 5'd0, 1'b0);
        n_checks++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL ill_occupied got %b exp 1", e1); end
        run_move(1'b0);
        n_checks++; if ({mv_xs[0], mv_ys[0], mv_cs[0]} !== {5'd0, 5'd1, 2'd0}) begin n_fail++;
            $display("FAIL ill_move got (%0d,%0d) c%0d exp (0,1) c0", mv_xs[0], mv_ys[0], mv_cs[0]); end
    endtask

    task automatic test_collision();
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        opp_valid = 1'b1; opp_two = 1'b0; opp_x1 = 5'd3; opp_y1 = 5'd3; start = 1'b1; n_stones = 1'b0;
        @(posedge clk); @(negedge clk);
        opp_valid = 1'b0; start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            if (done || mv_valid) seen_done++;
        end
        n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL coll_no_done got %0d exp 0", seen_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL coll_idle got busy=%b exp 0", busy); end
        send_opp(5'd3, 5'd3, 5'd0, 5'd0, 1'b0);
        n_checks++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL coll_stone_placed got %b exp 1", e1); end
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk); start = 1'b1; n_stones = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (100) @(negedge clk);
        n_checks++; if ({busy, opp_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_busy got %b exp 10", {busy, opp_ready}); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({opp_ready, busy, mv_valid, done, err_illegal, board_full} !== 6'b100000) begin n_fail++;
            $display("FAIL mid_reset_outs got %b exp 100000", {opp_ready, busy, mv_valid, done, err_illegal, board_full}); end
        run_move(1'b0);
        n_checks++; if (mv_n !== 1 || {mv_xs[0], mv_ys[0], mv_cs[0]} !== {5'd0, 5'd0, 2'd0}) begin n_fail++;
            $display("FAIL mid_cleared got n=%0d (%0d,%0d) c%0d exp n=1 (0,0) c0", mv_n, mv_xs[0], mv_ys[0], mv_cs[0]); end
    endtask

    task automatic test_small_board();
        reset_small();
        run_move3(1'b1);
        n_checks++; if (mv_n !== 2 || mv_k[0] !== 10) begin n_fail++;
            $display("FAIL sm_first got n=%0d k=%0d exp n=2 k=10", mv_n, mv_k[0]); end
        n_checks++; if ({mv_xs[0], mv_ys[0], mv_cs[0], mv_xs[1], mv_ys[1], mv_cs[1]} !==
                        {5'd0, 5'd0, 2'd0, 5'd0, 5'd1, 2'd1}) begin n_fail++;
            $display("FAIL sm_pair got (%0d,%0d)c%0d (%0d,%0d)c%0d exp (0,0)c0 (0,1)c1",
                     mv_xs[0], mv_ys[0], mv_cs[0], mv_xs[1], mv_ys[1], mv_cs[1]); end
        run_move3(1'b0);
        n_checks++; if ({mv_xs[0], mv_ys[0], mv_cs[0]} !== {5'd0, 5'd2, 2'd1}) begin n_fail++;
            $display("FAIL sm_saturate got (%0d,%0d) c%0d exp (0,2) c1", mv_xs[0], mv_ys[0], mv_cs[0]); end
        send_opp3(2'd1, 2'd0, 2'd1, 2'd1, 1'b1);
        n_checks++; if ({e1, e2} !== 2'b00) begin n_fail++; $display("FAIL sm_fill_a got %b exp 00", {e1, e2}); end
        send_opp3(2'd1, 2'd2, 2'd2, 2'd0, 1'b1);
        n_checks++; if ({e1, e2} !== 2'b00) begin n_fail++; $display("FAIL sm_fill_b got %b exp 00", {e1, e2}); end
        send_opp3(2'd2, 2'd1, 2'd2, 2'd2, 1'b1);
        n_checks++; if ({e1, e2} !== 2'b00) begin n_fail++; $display("FAIL sm_fill_c got %b exp 00", {e1, e2}); end
        send_opp3(2'd3, 2'd0, 2'd0, 2'd0, 1'b0);
        n_checks++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL sm_range got %b exp 1", e1); end
        run_move3(1'b0);
        n_checks++; if (mv_n !== 0) begin n_fail++; $display("FAIL sm_full_nomove got %0d exp 0", mv_n); end
        n_checks++; if (done_k !== 11) begin n_fail++; $display("FAIL sm_full_done got %0d exp 11", done_k); end
        repeat (3) @(negedge clk);
        n_checks++; if ({board_full3, opp_ready3} !== 2'b11) begin n_fail++;
            $display("FAIL sm_full_sticky got %b exp 11", {board_full3, opp_ready3}); end
        reset_small();
        n_checks++; if (board_full3 !== 1'b0) begin n_fail++; $display("FAIL sm_full_clear got %b exp 0", board_full3); end
    endtask

    initial begin
        rst = 1'b0; opp_valid = 1'b0; opp_two = 1'b0; start = 1'b0; n_stones = 1'b0;
        opp_x1 = '0; opp_y1 = '0; opp_x2 = '0; opp_y2 = '0;
        rst3 = 1'b0; opp_valid3 = 1'b0; opp_two3 = 1'b0; start3 = 1'b0; n_stones3 = 1'b0;
        opp_x13 = '0; opp_y13 = '0; opp_x23 = '0; opp_y23 = '0;
        reset_small();
        test_reset();
        test_single_move();
        test_back_to_back();
        test_defensive();
        test_illegal();
        test_collision();
        test_reset_mid_scan();
        test_small_board();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
